// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared GPU types for the warp barrier controller: request format, per-slot state and
// the default warp/barrier counts.
package vx_barrier_ctrl_pkg;

   localparam int unsigned CFG_NUM_WARPS    = 4;
   localparam int unsigned CFG_NUM_BARRIERS = 4;

   localparam int unsigned NW_BITS  = $clog2(CFG_NUM_WARPS);
   localparam int unsigned NB_BITS  = $clog2(CFG_NUM_BARRIERS);
   // Zero-width guards for single-warp / single-barrier configurations
   localparam int unsigned NW_WIDTH = (NW_BITS == 0) ? 1 : NW_BITS;
   localparam int unsigned NB_WIDTH = (NB_BITS == 0) ? 1 : NB_BITS;

   typedef struct packed {
      logic                valid;
      logic [NB_WIDTH-1:0] id;
      logic [NW_WIDTH-1:0] size_m1;
   } gpu_barrier_t;

   typedef struct packed {
      logic                     active;
      logic [NW_WIDTH-1:0]      count;
      logic [NW_WIDTH-1:0]      size_m1;
      logic [CFG_NUM_WARPS-1:0] wait_mask;
   } barrier_state_t;

endpackage

// File: rtl/vx_barrier_ctrl.sv
// Warp barrier controller: counts arrivals per barrier slot, holds arriving warps and
// releases them all with a registered one-cycle pulse when the last warp arrives.
module vx_barrier_ctrl
   import vx_barrier_ctrl_pkg::*;
#(
   parameter int unsigned NUM_WARPS    = CFG_NUM_WARPS,
   parameter int unsigned NUM_BARRIERS = CFG_NUM_BARRIERS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  gpu_barrier_t         barrier_req,
   input  logic [NW_WIDTH-1:0]  barrier_wid,
   output logic [NUM_WARPS-1:0] stall_mask,
   output logic                 release_valid,
   output logic [NB_WIDTH-1:0]  release_id,
   output logic [NUM_WARPS-1:0] release_mask,
   output logic                 error
);

   logic [NUM_WARPS-1:0]    wid_onehot;
   logic [NUM_WARPS-1:0]    wait_any;
   logic [NUM_WARPS-1:0]    wait_b [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]    rel_mask_b [NUM_BARRIERS];
   logic [NUM_BARRIERS-1:0] complete;
   logic [NUM_BARRIERS-1:0] mismatch;
   logic                    id_ok;
   logic                    dup;
   logic                    accept;

   logic                    rel_valid_d;
   logic [NB_WIDTH-1:0]     rel_id_d;
   logic [NUM_WARPS-1:0]    rel_mask_d;
   logic                    err_d;

   always_comb begin
      wid_onehot = '0;
      wid_onehot[barrier_wid] = 1'b1;
   end

   always_comb begin
      wait_any = '0;
      id_ok    = 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         wait_any = wait_any | wait_b[b];
         if (barrier_req.id == NB_WIDTH'(b)) id_ok = 1'b1;
      end
   end

   // A warp already parked at any barrier may not arrive again; such requests are dropped.
   assign dup    = |(wait_any & wid_onehot);
   assign accept = barrier_req.valid && id_ok && !dup;

   for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_bar
      barrier_state_t state_q;
      barrier_state_t state_d;
      logic           hit;
      logic           done;

      assign hit           = accept && (barrier_req.id == NB_WIDTH'(b));
      assign mismatch[b]   = hit && state_q.active && (barrier_req.size_m1 != state_q.size_m1);
      assign complete[b]   = done;
      assign wait_b[b]     = state_q.wait_mask;
      assign rel_mask_b[b] = state_q.wait_mask | wid_onehot;

      always_comb begin
         state_d = state_q;
         done    = 1'b0;
         if (hit) begin
            if (!state_q.active) begin
               if (barrier_req.size_m1 == '0) begin
                  done = 1'b1;
               end else begin
                  state_d.active    = 1'b1;
                  state_d.count     = NW_WIDTH'(1);
                  state_d.size_m1   = barrier_req.size_m1;
                  state_d.wait_mask = wid_onehot;
               end
            end else if (state_q.count < state_q.size_m1) begin
               // Mismatched size still counts against the latched size
               state_d.count     = state_q.count + NW_WIDTH'(1);
               state_d.wait_mask = state_q.wait_mask | wid_onehot;
            end else begin
               done = 1'b1;
            end
            if (done) state_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) state_q <= '0;
         else          state_q <= state_d;
      end
   end

   // At most one request per cycle, so at most one slot completes.
   always_comb begin
      rel_valid_d = |complete;
      rel_id_d    = '0;
      rel_mask_d  = '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         if (complete[b]) begin
            rel_id_d   = NB_WIDTH'(b);
            rel_mask_d = rel_mask_b[b];
         end
      end
      err_d = barrier_req.valid && (!id_ok || dup || (|mismatch));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         release_valid <= 1'b0;
         release_id    <= '0;
         release_mask  <= '0;
         error         <= 1'b0;
      end else begin
         release_valid <= rel_valid_d;
         release_id    <= rel_id_d;
         release_mask  <= rel_mask_d;
         error         <= err_d;
      end
   end

   assign stall_mask = wait_any;

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Directed bench for vx_barrier_ctrl with 4 warps and 4 barrier slots.
module tb_vx_barrier_ctrl;
   import vx_barrier_ctrl_pkg::*;

   logic               clk;
   logic               reset_n;
   gpu_barrier_t       barrier_req;
   logic [NW_WIDTH-1:0] barrier_wid;
   logic [3:0]         stall_mask;
   logic               release_valid;
   logic [NB_WIDTH-1:0] release_id;
   logic [3:0]         release_mask;
   logic               error;

   int n_checks = 0;
   int n_fail   = 0;

   vx_barrier_ctrl #(
      .NUM_WARPS    (4),
      .NUM_BARRIERS (4)
   ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .barrier_req   (barrier_req),
      .barrier_wid   (barrier_wid),
      .stall_mask    (stall_mask),
      .release_valid (release_valid),
      .release_id    (release_id),
      .release_mask  (release_mask),
      .error         (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request for one cycle; returns #1 after the edge that captured it.
   task automatic send(input int wid, input int id, input int sz);
      barrier_req.valid   = 1'b1;
      barrier_req.id      = NB_WIDTH'(id);
      barrier_req.size_m1 = NW_WIDTH'(sz);
      barrier_wid         = NW_WIDTH'(wid);
      step();
      barrier_req.valid   = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      barrier_req = '0;
      barrier_wid = '0;
      step();
      step();
      check_eq("rst_stall", stall_mask, 4'b0000);
      check_eq("rst_rel_valid", release_valid, 1'b0);
      check_eq("rst_rel_id", release_id, 0);
      check_eq("rst_rel_mask", release_mask, 4'b0000);
      check_eq("rst_error", error, 1'b0);
      reset_n = 1'b1;
      step();

      // Three warps meet at barrier 1
      send(0, 1, 2);
      check_eq("b3_stall0", stall_mask, 4'b0001);
      check_eq("b3_norel0", release_valid, 1'b0);
      send(1, 1, 2);
      check_eq("b3_stall1", stall_mask, 4'b0011);
      check_eq("b3_norel1", release_valid, 1'b0);
      send(2, 1, 2);
      check_eq("b3_rel_valid", release_valid, 1'b1);
      check_eq("b3_rel_id", release_id, 1);
      check_eq("b3_rel_mask", release_mask, 4'b0111);
      check_eq("b3_stall_clr", stall_mask, 4'b0000);
      check_eq("b3_noerr", error, 1'b0);
      step();
      check_eq("b3_pulse_end", release_valid, 1'b0);

      // Single-warp barrier completes immediately
      send(3, 0, 0);
      check_eq("b1_rel_valid", release_valid, 1'b1);
      check_eq("b1_rel_id", release_id, 0);
      check_eq("b1_rel_mask", release_mask, 4'b1000);
      check_eq("b1_stall", stall_mask, 4'b0000);
      step();
      check_eq("b1_stall_after", stall_mask, 4'b0000);
      check_eq("b1_pulse_end", release_valid, 1'b0);

      // Duplicate arrival is flagged and dropped
      send(2, 2, 1);
      check_eq("dup_stall0", stall_mask, 4'b0100);
      check_eq("dup_noerr0", error, 1'b0);
      send(2, 2, 1);
      check_eq("dup_error", error, 1'b1);
      check_eq("dup_norel", release_valid, 1'b0);
      check_eq("dup_stall1", stall_mask, 4'b0100);
      step();
      check_eq("dup_err_end", error, 1'b0);
      send(0, 2, 1);
      check_eq("dup_rel_valid", release_valid, 1'b1);
      check_eq("dup_rel_mask", release_mask, 4'b0101);
      check_eq("dup_rel_id", release_id, 2);

      // Size mismatch flagged, counted with the latched size
      send(0, 3, 1);
      check_eq("mis_stall", stall_mask, 4'b0001);
      send(1, 3, 2);
      check_eq("mis_error", error, 1'b1);
      check_eq("mis_rel_valid", release_valid, 1'b1);
      check_eq("mis_rel_id", release_id, 3);
      check_eq("mis_rel_mask", release_mask, 4'b0011);
      step();
      check_eq("mis_err_end", error, 1'b0);

      // Reset with warps parked
      send(0, 1, 2);
      send(1, 1, 2);
      check_eq("rr_stall", stall_mask, 4'b0011);
      reset_n = 1'b0;
      step();
      check_eq("rr_stall_clr", stall_mask, 4'b0000);
      check_eq("rr_norel", release_valid, 1'b0);
      reset_n = 1'b1;
      send(2, 1, 1);
      check_eq("rr_new_stall", stall_mask, 4'b0100);
      check_eq("rr_new_norel", release_valid, 1'b0);
      send(3, 1, 1);
      check_eq("rr_rel_valid", release_valid, 1'b1);
      check_eq("rr_rel_mask", release_mask, 4'b1100);

      // Interleaved barriers, then a new generation in the release cycle
      send(0, 0, 1);
      send(1, 1, 1);
      check_eq("il_stall", stall_mask, 4'b0011);
      send(2, 0, 1);
      check_eq("il_rel0_valid", release_valid, 1'b1);
      check_eq("il_rel0_id", release_id, 0);
      check_eq("il_rel0_mask", release_mask, 4'b0101);
      check_eq("il_stall0", stall_mask, 4'b0010);
      send(3, 1, 1);
      check_eq("il_rel1_valid", release_valid, 1'b1);
      check_eq("il_rel1_id", release_id, 1);
      check_eq("il_rel1_mask", release_mask, 4'b1010);
      check_eq("il_stall1", stall_mask, 4'b0000);
      send(1, 1, 1);
      check_eq("gen_stall", stall_mask, 4'b0010);
      check_eq("gen_norel", release_valid, 1'b0);
      check_eq("gen_noerr", error, 1'b0);
      send(3, 1, 1);
      check_eq("gen_rel_valid", release_valid, 1'b1);
      check_eq("gen_rel_mask", release_mask, 4'b1010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_barrier_ctrl.md
VX_BARRIER_CTRL -- requirements
Module: VX_barrier_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS, number of warps tracked.
REQ-002 SHALL have parameter NUM_BARRIERS, default `NUM_BARRIERS, number of barrier slots.
REQ-003 SHALL have port clk  input  1  sole clock; one clock domain.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port barrier_req  input  $bits(gpu_barrier_t)  request {valid, id, size_m1} from the GPU unit.
REQ-006 SHALL have port barrier_wid  input  `UP(`NW_BITS)  id of the warp issuing barrier_req.
REQ-007 SHALL have port stall_mask  output  NUM_WARPS  warps currently held at any barrier.
REQ-008 SHALL have port release_valid  output  1  one-cycle pulse: a barrier completed.
REQ-009 SHALL have port release_id  output  `NB_BITS  barrier that completed.
REQ-010 SHALL have port release_mask  output  NUM_WARPS  warps freed by the completion.
REQ-011 SHALL have port error  output  1  one-cycle pulse: protocol violation detected.

Function
REQ-012 SHALL keep, per barrier b: active[b], count[b] (`UP(`NW_BITS) bits), size_m1[b] (latched), wait_mask[b] (NUM_WARPS bits).
REQ-013 SHALL accept one request per cycle when barrier_req.valid=1; no back-pressure.
REQ-014 SHALL, for a request to inactive barrier b with size_m1>0, set active[b]=1, count[b]=1, latch size_m1, and set wait_mask[b][wid].
REQ-015 SHALL, for a request to active barrier b with count[b]<size_m1[b], increment count[b] and set wait_mask[b][wid].
REQ-016 SHALL, for a request with count[b]==size_m1[b] (including size_m1=0 on an inactive barrier), complete barrier b.
REQ-017 SHALL, on completion, register release_valid=1, release_id=b, release_mask=wait_mask[b]|(1<<wid) in the next cycle; clear active[b], count[b] and wait_mask[b] in that same next cycle.
REQ-018 SHALL drive stall_mask as the registered OR of all wait_mask[]; a waiting warp's bit clears in the same cycle that release_valid is asserted.
REQ-019 SHALL hold release_valid low in all cycles other than the one following a completing request; release_id and release_mask are don't-care when release_valid=0.
REQ-020 SHALL pulse error one cycle after a request whose wid is already set in any wait_mask, and ignore that request (no state change).
REQ-021 SHALL pulse error one cycle after a request to active barrier b whose size_m1 differs from the latched value; the request is still counted using the latched size.
REQ-022 SHALL ignore a request with barrier_req.id>=NUM_BARRIERS and pulse error.
REQ-023 SHALL allow a new request to barrier b in the cycle release_valid is asserted for b; that request starts a new generation.

Reset
REQ-024 SHALL, while reset_n=0 at a rising clk edge, clear all active, count, wait_mask; outputs stall_mask=0, release_valid=0, release_id=0, release_mask=0, error=0.
REQ-025 SHALL, on reset mid-operation, discard all waiting warps without a release pulse.

Structure
REQ-026 SHALL take gpu_barrier_t and NB_BITS/NW_BITS from VX_gpu_types; a barrier_state_t {active, count, size_m1, wait_mask} typedef SHALL be added to that package.
REQ-027 SHALL be a single module with a generate loop over barriers; no sub-module required.

Verification (NUM_WARPS=4, NUM_BARRIERS=4)
REQ-028 SHALL test: warps 0,1,2 to id=1 size_m1=2 on consecutive cycles -> stall_mask 0001,0011 then release_valid=1 id=1 mask=0111, stall_mask=0000.
REQ-029 SHALL test: warp 3 to id=0 size_m1=0 -> next cycle release_valid=1 mask=1000, stall_mask never set.
REQ-030 SHALL test: warp 2 to id=2 size_m1=1, then warp 2 again -> error pulse, count stays 1, no release.
REQ-031 SHALL test: warp 0 to id=3 size_m1=1, warp 1 to id=3 size_m1=2 -> error pulse and release mask=0011.
REQ-032 SHALL test: warps 0,1 waiting on id=1, reset_n=0 one cycle -> stall_mask=0000, no release_valid, subsequent barrier works normally.
REQ-033 SHALL test: two barriers interleaved (id=0 warps 0,2; id=1 warps 1,3; size_m1=1) -> two separate releases with masks 0101 and 1010.
